// File: rtl/io_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : io_pkg
//  Description : Shared FSM state encoding and index-width helpers for the
//                IO/interrupt controller.
//  Revision    : 1.0
// ============================================================================
package io_pkg;

    localparam int c_state_w = 2;

    typedef enum logic [c_state_w-1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } irq_state_e;

    // Index width for n items; never below one bit so single-entry buses stay legal.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/irq_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : irq_arbiter
//  Description : Edge-detect, mask, pending and fixed-priority request FSM.
//  Revision    : 1.0
// ============================================================================
module irq_arbiter
    import io_pkg::*;
#(
    parameter int NIRQ = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NIRQ-1:0]         irq_in,
    input  logic                    mask_we,
    input  logic [NIRQ-1:0]         mask_wdata,
    input  logic                    irq_ack,
    input  logic                    irq_eoi,
    output logic                    irq_req,
    output logic [idx_w(NIRQ)-1:0]  irq_vec
);

    localparam int c_vw = idx_w(NIRQ);

    irq_state_e         r_state;
    irq_state_e         w_state_nx;
    logic [NIRQ-1:0]    r_irq_d;
    logic [NIRQ-1:0]    r_pending;
    logic [NIRQ-1:0]    r_mask;
    logic [c_vw-1:0]    r_vec;

    logic [NIRQ-1:0]    w_edge;
    logic [NIRQ-1:0]    w_active;
    logic [NIRQ-1:0]    w_clr;
    logic               w_any;
    logic               w_take_ack;
    logic [c_vw-1:0]    w_win;

    assign w_edge     = irq_in & ~r_irq_d & ~r_mask;
    assign w_active   = r_pending & ~r_mask;
    assign w_any      = |w_active;
    assign w_take_ack = (r_state == ST_REQ) && irq_ack;
    assign w_clr      = w_take_ack ? (NIRQ'(1) << r_vec) : '0;

    // Scan downward so the lowest active index is the last assignment.
    always_comb begin
        w_win = '0;
        for (int i = NIRQ - 1; i >= 0; i--) begin
            if (w_active[i]) begin
                w_win = c_vw'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_irq_d   <= '0;
            r_pending <= '0;
            r_mask    <= '1;
        end else begin
            r_irq_d   <= irq_in;
            r_pending <= (r_pending & ~w_clr) | w_edge;
            if (mask_we) begin
                r_mask <= mask_wdata;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_vec   <= '0;
        end else begin
            r_state <= w_state_nx;
            if (r_state == ST_IDLE && w_any) begin
                r_vec <= w_win;
            end
        end
    end

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            ST_IDLE:    if (w_any)   w_state_nx = ST_REQ;
            ST_REQ:     if (irq_ack) w_state_nx = ST_SERVICE;
            ST_SERVICE: if (irq_eoi) w_state_nx = ST_IDLE;
            default:                 w_state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        irq_req = (r_state == ST_REQ);
        irq_vec = r_vec;
    end

endmodule
`default_nettype wire

// File: rtl/io_irq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : io_irq_ctrl
//  Description : Parallel IO ports plus edge-triggered interrupt controller.
//                Define IO_SYNC_EN to add a two-flop synchroniser on e_bus.
//  Revision    : 1.0
// ============================================================================
module io_irq_ctrl
    import io_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int NPORTS = 4,
    parameter int NIRQ   = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NPORTS*DATA_W-1:0]    e_bus,
    output logic [NPORTS*DATA_W-1:0]    s_bus,
    input  logic [idx_w(NPORTS)-1:0]    port_sel,
    input  logic                        we_es,
    input  logic [DATA_W-1:0]           wdata,
    output logic [DATA_W-1:0]           rdata,
    input  logic [NIRQ-1:0]             irq_in,
    input  logic                        mask_we,
    input  logic [NIRQ-1:0]             mask_wdata,
    output logic                        irq_req,
    input  logic                        irq_ack,
    output logic [idx_w(NIRQ)-1:0]      irq_vec,
    input  logic                        irq_eoi
);

    localparam int c_psw = idx_w(NPORTS);

    logic [NPORTS*DATA_W-1:0]   w_e_view;
    logic [DATA_W-1:0]          r_port [NPORTS];
    logic [DATA_W-1:0]          w_in   [NPORTS];

`ifdef IO_SYNC_EN
    logic [NPORTS*DATA_W-1:0]   r_sync1;
    logic [NPORTS*DATA_W-1:0]   r_sync2;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= e_bus;
            r_sync2 <= r_sync1;
        end
    end

    assign w_e_view = r_sync2;
`else
    assign w_e_view = e_bus;
`endif

    generate
        for (genvar p = 0; p < NPORTS; p++) begin : g_port
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    r_port[p] <= '0;
                end else if (we_es && port_sel == c_psw'(p)) begin
                    r_port[p] <= wdata;
                end
            end

            assign s_bus[p*DATA_W +: DATA_W] = r_port[p];
            assign w_in[p]                   = w_e_view[p*DATA_W +: DATA_W];
        end
    endgenerate

    assign rdata = w_in[port_sel];

    irq_arbiter #(
        .NIRQ       (NIRQ)
    ) u_irq_arbiter (
        .clk        (clk),
        .reset      (reset),
        .irq_in     (irq_in),
        .mask_we    (mask_we),
        .mask_wdata (mask_wdata),
        .irq_ack    (irq_ack),
        .irq_eoi    (irq_eoi),
        .irq_req    (irq_req),
        .irq_vec    (irq_vec)
    );

endmodule
`default_nettype wire

// File: tb/tb_io_irq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_io_irq_ctrl
//  Description : Directed self-checking bench for io_irq_ctrl.
//  Revision    : 1.0
// ============================================================================
module tb_io_irq_ctrl;

    logic        clk;
    logic        reset;
    logic [31:0] e_bus;
    logic [31:0] s_bus;
    logic [1:0]  port_sel;
    logic        we_es;
    logic [7:0]  wdata;
    logic [7:0]  rdata;
    logic [3:0]  irq_in;
    logic        mask_we;
    logic [3:0]  mask_wdata;
    logic        irq_req;
    logic        irq_ack;
    logic [1:0]  irq_vec;
    logic        irq_eoi;

    int n_cmp;
    int n_err;

    io_irq_ctrl #(
        .DATA_W     (8),
        .NPORTS     (4),
        .NIRQ       (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .e_bus      (e_bus),
        .s_bus      (s_bus),
        .port_sel   (port_sel),
        .we_es      (we_es),
        .wdata      (wdata),
        .rdata      (rdata),
        .irq_in     (irq_in),
        .mask_we    (mask_we),
        .mask_wdata (mask_wdata),
        .irq_req    (irq_req),
        .irq_ack    (irq_ack),
        .irq_vec    (irq_vec),
        .irq_eoi    (irq_eoi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_mask(input logic [3:0] m);
        mask_we    = 1'b1;
        mask_wdata = m;
        tick();
        mask_we    = 1'b0;
    endtask

    initial begin
        n_cmp      = 0;
        n_err      = 0;
        reset      = 1'b0;
        e_bus      = '0;
        port_sel   = '0;
        we_es      = 1'b0;
        wdata      = '0;
        irq_in     = '0;
        mask_we    = 1'b0;
        mask_wdata = '0;
        irq_ack    = 1'b0;
        irq_eoi    = 1'b0;

        tick(3);
        check_eq("rst_s_bus",   s_bus,   32'h0);
        check_eq("rst_irq_req", irq_req, 32'h0);
        check_eq("rst_irq_vec", irq_vec, 32'h0);
        reset = 1'b1;
        tick();

        // Output port writes
        port_sel = 2'd2; wdata = 8'hA5; we_es = 1'b1;
        tick();
        we_es = 1'b0;
        check_eq("wr_port2", s_bus, 32'h00A5_0000);
        port_sel = 2'd0; wdata = 8'h11; we_es = 1'b1;
        tick();
        we_es = 1'b0; wdata = 8'hFF;
        tick();
        check_eq("wr_port0_hold", s_bus, 32'h00A5_0011);

        // Input port read path
        port_sel = 2'd1;
        e_bus    = 32'h5A00_3C00;
        #1;
`ifdef IO_SYNC_EN
        check_eq("rd_before_edges", rdata, 32'h00);
        tick();
        check_eq("rd_after_1edge", rdata, 32'h00);
        tick();
        check_eq("rd_after_2edges", rdata, 32'h3C);
`else
        check_eq("rd_comb_port1", rdata, 32'h3C);
        tick(2);
`endif
        port_sel = 2'd3;
        #1;
        check_eq("rd_port3", rdata, 32'h5A);

        // Simultaneous edges on lines 2 and 0: lowest index first
        set_mask(4'b0000);
        irq_in = 4'b0101;
        tick();
        irq_in = 4'b0000;
        check_eq("pri_idle_first", irq_req, 32'h0);
        tick();
        check_eq("pri_req0",  irq_req, 32'h1);
        check_eq("pri_vec0",  irq_vec, 32'h0);
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        check_eq("pri_svc_req", irq_req, 32'h0);
        check_eq("pri_svc_vec", irq_vec, 32'h0);
        irq_eoi = 1'b1;
        tick();
        irq_eoi = 1'b0;
        check_eq("pri_eoi_idle", irq_req, 32'h0);
        tick();
        check_eq("pri_req2", irq_req, 32'h1);
        check_eq("pri_vec2", irq_vec, 32'h2);
        irq_ack = 1'b1; tick(); irq_ack = 1'b0;
        irq_eoi = 1'b1; tick(); irq_eoi = 1'b0;
        tick(2);
        check_eq("pri_drained", irq_req, 32'h0);

        // Stray eoi in IDLE is ignored, stray ack too
        irq_eoi = 1'b1; irq_ack = 1'b1; tick(); irq_eoi = 1'b0; irq_ack = 1'b0;
        tick();
        check_eq("stray_ack_eoi", irq_req, 32'h0);

        // Edge on a masked line is dropped
        set_mask(4'b1111);
        irq_in = 4'b0010;
        tick();
        irq_in = 4'b0000;
        tick(2);
        check_eq("masked_edge", irq_req, 32'h0);
        set_mask(4'b0000);
        tick(2);
        check_eq("masked_then_unmask", irq_req, 32'h0);

        // New edge coincident with ack on the same line: set wins
        irq_in = 4'b0001;
        tick();
        irq_in = 4'b0000;
        tick();
        check_eq("coin_req",  irq_req, 32'h1);
        check_eq("coin_vec",  irq_vec, 32'h0);
        irq_in  = 4'b0001;
        irq_ack = 1'b1;
        tick();
        irq_in  = 4'b0000;
        irq_ack = 1'b0;
        check_eq("coin_svc", irq_req, 32'h0);
        tick(2);
        check_eq("coin_no_nest", irq_req, 32'h0);
        irq_eoi = 1'b1;
        tick();
        irq_eoi = 1'b0;
        check_eq("coin_eoi_idle", irq_req, 32'h0);
        tick();
        check_eq("coin_rereq",     irq_req, 32'h1);
        check_eq("coin_rereq_vec", irq_vec, 32'h0);
        irq_ack = 1'b1; tick(); irq_ack = 1'b0;
        irq_eoi = 1'b1; tick(); irq_eoi = 1'b0;
        tick(2);
        check_eq("coin_drained", irq_req, 32'h0);

        // Reset during SERVICE
        irq_in = 4'b1000;
        tick();
        irq_in = 4'b0000;
        tick();
        check_eq("svc_req3", irq_req, 32'h1);
        check_eq("svc_vec3", irq_vec, 32'h3);
        irq_ack = 1'b1; tick(); irq_ack = 1'b0;
        reset = 1'b0;
        #1;
        check_eq("arst_irq_req", irq_req, 32'h0);
        check_eq("arst_irq_vec", irq_vec, 32'h0);
        check_eq("arst_s_bus",   s_bus,   32'h0);
`ifdef IO_SYNC_EN
        check_eq("arst_rdata_sync", rdata, 32'h0);
`endif
        tick();
        reset = 1'b1;
        tick(3);
        check_eq("post_rst_quiet", irq_req, 32'h0);
        // Mask returns to all-ones: an edge right after release is ignored
        irq_in = 4'b0010;
        tick();
        irq_in = 4'b0000;
        tick(2);
        check_eq("post_rst_masked", irq_req, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/io_irq_ctrl.md
IO_IRQ_CTRL -- requirements
Module: io_irq_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 8, port data width in bits.
REQ-002 SHALL have parameter NPORTS, default 4, number of input ports and output ports (power of two, 2..16).
REQ-003 SHALL have parameter NIRQ, default 4, number of interrupt request lines (1..8).
REQ-004 SHALL have port clk, input, 1, sole clock, rising edge.
REQ-005 SHALL have port reset, input, 1, asynchronous, active-low reset.
REQ-006 SHALL have port e_bus, input, NPORTS*DATA_W, external input ports; port i occupies bits [i*DATA_W +: DATA_W].
REQ-007 SHALL have port s_bus, output, NPORTS*DATA_W, registered external output ports, packed like e_bus.
REQ-008 SHALL have port port_sel, input, clog2(NPORTS), port index for both read and write.
REQ-009 SHALL have port we_es, input, 1, write strobe for output port port_sel.
REQ-010 SHALL have port wdata, input, DATA_W, write data.
REQ-011 SHALL have port rdata, output, DATA_W, input-port read data.
REQ-012 SHALL have port irq_in, input, NIRQ, interrupt request lines, synchronous to clk.
REQ-013 SHALL have port mask_we, input, 1; port mask_wdata, input, NIRQ; mask register write, 1 = line masked.
REQ-014 SHALL have port irq_req, output, 1, interrupt request to the control unit.
REQ-015 SHALL have port irq_ack, input, 1, single-cycle acknowledge from the control unit.
REQ-016 SHALL have port irq_vec, output, clog2(NIRQ) (min 1), index of the line being requested or serviced.
REQ-017 SHALL have port irq_eoi, input, 1, single-cycle end-of-interrupt.

Function
REQ-018 SHALL update output port port_sel with wdata on the rising edge where we_es=1; other ports hold.
REQ-019 SHALL drive rdata combinationally from the (synchronised, see REQ-031) input port selected by port_sel.
REQ-020 SHALL detect rising edges of irq_in against a one-cycle delayed copy; an edge on line k sets pending[k] on the same clock edge that samples it.
REQ-021 SHALL ignore edges on masked lines; masking an already pending line holds it pending but excludes it from arbitration.
REQ-022 SHALL arbitrate unmasked pending lines with fixed priority, lowest index highest.
REQ-023 SHALL implement FSM IDLE, REQ, SERVICE: IDLE->REQ when any unmasked pending; REQ->SERVICE on irq_ack; SERVICE->IDLE on irq_eoi.
REQ-024 SHALL assert irq_req only in REQ; irq_vec SHALL be captured on entry to REQ and held stable through REQ and SERVICE.
REQ-025 SHALL clear pending[irq_vec] on the irq_ack edge; if a new edge on that line arrives in the same cycle, pending SHALL remain set (set wins).
REQ-026 SHALL not nest: pending lines accumulate during SERVICE and are arbitrated after return to IDLE, earliest REQ one cycle after eoi.
REQ-027 SHALL ignore irq_ack outside REQ and irq_eoi outside SERVICE.

Reset
REQ-028 SHALL on reset=0 clear s_bus, pending, edge-detect history and synchronisers to 0, set mask to all-ones, FSM to IDLE, irq_req=0, irq_vec=0.
REQ-029 SHALL abandon any in-progress request or service on reset; no interrupt is delivered after release until a new edge occurs.

Configuration
REQ-030 SHALL compile a two-flop synchroniser on every e_bus bit when IO_SYNC_EN is defined.
REQ-031 SHALL with IO_SYNC_EN make an e_bus change visible on rdata after the second rising edge; without it rdata SHALL follow e_bus combinationally.

Structure
REQ-032 SHALL place the FSM state enum and the clog2-based width helper constants in shared package io_pkg.
REQ-033 SHALL implement arbitration and FSM in sub-module irq_arbiter; port registers and synchronisers stay in io_irq_ctrl.

Verification
REQ-034 Write port 2 with 8'hA5 -> s_bus[23:16]=8'hA5 next cycle, other ports 0.
REQ-035 IO_SYNC_EN: e_bus port 1 = 8'h3C, port_sel=1 -> rdata=8'h3C after 2 edges, old value before.
REQ-036 Mask=4'b0000, pulse irq_in[2] and irq_in[0] same cycle -> irq_req with irq_vec=0; ack, eoi -> second REQ with irq_vec=2.
REQ-037 Mask=4'b1111, pulse irq_in[1] -> irq_req stays 0; unmask -> still 0 (edge ignored while masked).
REQ-038 In REQ, new irq_in[0] edge coincident with irq_ack (irq_vec=0) -> pending[0] stays 1, REQ re-entered one cycle after eoi.
REQ-039 Assert reset during SERVICE -> irq_req=0, irq_vec=0, s_bus=0, mask=all-ones immediately, no request after release.
